// File: rtl/iir_biquad_seq_pkg.sv
// Shared definitions for the serial biquad sequencer: FSM states, mux select codes,
// accumulator width and saturation limits.
package iir_biquad_seq_pkg;

   localparam int N_DEF = 16;
   localparam int F_DEF = 14;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_MA1,
      ST_MA2,
      ST_STF,
      ST_MB0,
      ST_MB1,
      ST_MB2,
      ST_OUT
   } state_e;

   // Coefficient selects (controlS)
   localparam logic [2:0] SEL_S_ZERO = 3'd0;
   localparam logic [2:0] SEL_A1     = 3'd1;
   localparam logic [2:0] SEL_A2     = 3'd2;
   localparam logic [2:0] SEL_B0     = 3'd3;
   localparam logic [2:0] SEL_B1     = 3'd4;
   localparam logic [2:0] SEL_B2     = 3'd5;

   // State-word selects (controlC) and input/output selects (controlZ)
   localparam logic [1:0] SEL_C_ZERO = 2'd0;
   localparam logic [1:0] SEL_FK1    = 2'd1;
   localparam logic [1:0] SEL_FK2    = 2'd2;
   localparam logic [1:0] SEL_FK     = 2'd3;
   localparam logic [1:0] SEL_Z_ZERO = 2'd0;
   localparam logic [1:0] SEL_UK     = 2'd1;
   localparam logic [1:0] SEL_YK     = 2'd2;

   function automatic int acc_width(input int n);
      return 2 * n + 2;
   endfunction

   function automatic longint sat_max(input int n);
      return (longint'(1) <<< (n - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int n);
      return -(longint'(1) <<< (n - 1));
   endfunction

endpackage

// File: rtl/biquad_sat.sv
// Shift the accumulator down by F and clamp it to the signed N-bit range.
// Optional macro BIQUAD_ROUND_EN: round half up instead of truncating toward -inf.
module biquad_sat
   import iir_biquad_seq_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int F = F_DEF
) (
   input  logic signed [2*N+1:0] acc_i,
   output logic signed [N-1:0]   sat_o
);

   localparam int AW = acc_width(N);
   localparam logic signed [AW-1:0] SAT_HI = AW'(sat_max(N));
   localparam logic signed [AW-1:0] SAT_LO = AW'(sat_min(N));

   logic signed [AW-1:0] biased;
   logic signed [AW-1:0] shifted;

   always_comb begin
`ifdef BIQUAD_ROUND_EN
      biased = acc_i + (AW'(1) <<< (F - 1));
`else
      biased = acc_i;
`endif
      shifted = biased >>> F;
      if (shifted > SAT_HI)      sat_o = SAT_HI[N-1:0];
      else if (shifted < SAT_LO) sat_o = SAT_LO[N-1:0];
      else                       sat_o = shifted[N-1:0];
   end

endmodule

// File: rtl/iir_biquad_seq.sv
// Nine-cycle serial direct-form-II biquad: drives the coefficient/state mux selects and
// multiply-accumulates the returned words. Optional macro BIQUAD_ROUND_EN (see biquad_sat).
module iir_biquad_seq
   import iir_biquad_seq_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int F = F_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic signed [N-1:0] sample_in,
   output logic                in_ready,
   input  logic signed [N-1:0] muxS,
   input  logic signed [N-1:0] muxC,
   input  logic signed [N-1:0] muxZ,
   output logic [2:0]          controlS,
   output logic [1:0]          controlC,
   output logic [1:0]          controlZ,
   output logic signed [N-1:0] fk,
   output logic signed [N-1:0] fk1,
   output logic signed [N-1:0] fk2,
   output logic signed [N-1:0] Uk,
   output logic signed [N-1:0] yk,
   output logic                y_valid
);

   localparam int AW = acc_width(N);

   state_e state_q, state_d;
   logic signed [AW-1:0]  acc_q, acc_d;
   logic signed [N-1:0]   fk_q, fk_d, fk1_q, fk1_d, fk2_q, fk2_d;
   logic signed [N-1:0]   uk_q, uk_d, yk_q, yk_d;
   logic                  y_valid_q, y_valid_d;
   logic signed [2*N-1:0] prod;
   logic signed [N-1:0]   sat_val;

   assign prod = (2*N)'(muxS) * (2*N)'(muxC);

   // STF and OUT both scale the accumulator as it stands, so one instance serves both.
   biquad_sat #(.N(N), .F(F)) u_sat (
      .acc_i (acc_q),
      .sat_o (sat_val)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         acc_q     <= '0;
         fk_q      <= '0;
         fk1_q     <= '0;
         fk2_q     <= '0;
         uk_q      <= '0;
         yk_q      <= '0;
         y_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         fk_q      <= fk_d;
         fk1_q     <= fk1_d;
         fk2_q     <= fk2_d;
         uk_q      <= uk_d;
         yk_q      <= yk_d;
         y_valid_q <= y_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid) state_d = ST_LOAD;
         ST_LOAD: state_d = ST_MA1;
         ST_MA1:  state_d = ST_MA2;
         ST_MA2:  state_d = ST_STF;
         ST_STF:  state_d = ST_MB0;
         ST_MB0:  state_d = ST_MB1;
         ST_MB1:  state_d = ST_MB2;
         ST_MB2:  state_d = ST_OUT;
         ST_OUT:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      controlS = SEL_S_ZERO;
      controlC = SEL_C_ZERO;
      controlZ = SEL_Z_ZERO;
      in_ready = 1'b0;
      case (state_q)
         ST_IDLE: in_ready = 1'b1;
         ST_LOAD: controlZ = SEL_UK;
         ST_MA1:  begin controlS = SEL_A1; controlC = SEL_FK1; end
         ST_MA2:  begin controlS = SEL_A2; controlC = SEL_FK2; end
         ST_MB0:  begin controlS = SEL_B0; controlC = SEL_FK;  end
         ST_MB1:  begin controlS = SEL_B1; controlC = SEL_FK1; end
         ST_MB2:  begin controlS = SEL_B2; controlC = SEL_FK2; end
         ST_OUT:  controlZ = SEL_YK;
         default: ;
      endcase
   end

   always_comb begin
      acc_d     = acc_q;
      fk_d      = fk_q;
      fk1_d     = fk1_q;
      fk2_d     = fk2_q;
      uk_d      = uk_q;
      yk_d      = yk_q;
      y_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: if (in_valid) uk_d = sample_in;
         ST_LOAD: acc_d = AW'(muxZ) <<< F;
         ST_MA1, ST_MA2, ST_MB1, ST_MB2: acc_d = acc_q + AW'(prod);
         ST_STF:  fk_d = sat_val;
         // The output sum starts fresh; the feedback sum is no longer needed.
         ST_MB0:  acc_d = AW'(prod);
         ST_OUT: begin
            yk_d      = sat_val;
            fk2_d     = fk1_q;
            fk1_d     = fk_q;
            y_valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   assign fk      = fk_q;
   assign fk1     = fk1_q;
   assign fk2     = fk2_q;
   assign Uk      = uk_q;
   assign yk      = yk_q;
   assign y_valid = y_valid_q;

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Bench for iir_biquad_seq: coefficient mux model, vector table, corner sequences and
// randomized frames against a plain-arithmetic biquad model.
module tb_iir_biquad_seq;

   localparam int N = 16;
   localparam int F = 14;
   localparam longint MAXV = 32767;
   localparam longint MINV = -32768;
   localparam longint CA1 = 32112;
   localparam longint CA2 = -15736;
   localparam longint CB0 = 3;
   localparam longint CB1 = 6;
   localparam longint CB2 = 3;
`ifdef BIQUAD_ROUND_EN
   localparam longint IMP_Y1 = 12;
`else
   localparam longint IMP_Y1 = 11;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic in_valid = 1'b0;
   logic signed [N-1:0] sample_in = '0;
   logic in_ready, y_valid;
   logic signed [N-1:0] muxS, muxC, muxZ;
   logic [2:0] controlS;
   logic [1:0] controlC, controlZ;
   logic signed [N-1:0] fk, fk1, fk2, Uk, yk;

   int n_cmp = 0;
   int n_err = 0;
   longint m_fk1 = 0;
   longint m_fk2 = 0;

   always #5 clk = ~clk;

   iir_biquad_seq #(.N(N), .F(F)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .sample_in(sample_in),
      .in_ready(in_ready), .muxS(muxS), .muxC(muxC), .muxZ(muxZ),
      .controlS(controlS), .controlC(controlC), .controlZ(controlZ),
      .fk(fk), .fk1(fk1), .fk2(fk2), .Uk(Uk), .yk(yk), .y_valid(y_valid)
   );

   // Coefficient / operand multiplexer around the sequencer
   always_comb begin
      case (controlS)
         3'd1:    muxS = N'(CA1);
         3'd2:    muxS = N'(CA2);
         3'd3:    muxS = N'(CB0);
         3'd4:    muxS = N'(CB1);
         3'd5:    muxS = N'(CB2);
         default: muxS = '0;
      endcase
      case (controlC)
         2'd1:    muxC = fk1;
         2'd2:    muxC = fk2;
         2'd3:    muxC = fk;
         default: muxC = '0;
      endcase
      case (controlZ)
         2'd1:    muxZ = Uk;
         2'd2:    muxZ = yk;
         default: muxZ = '0;
      endcase
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic longint scale_down(input longint a);
`ifdef BIQUAD_ROUND_EN
      a = a + (longint'(1) <<< (F - 1));
`endif
      return a >>> F;
   endfunction

   function automatic longint sat_n(input longint v);
      if (v > MAXV) return MAXV;
      if (v < MINV) return MINV;
      return v;
   endfunction

   // One sample of the direct-form-II recurrence with exact integer sums.
   task automatic model_step(input longint u, output longint f, output longint y);
      f = sat_n(scale_down(u * (longint'(1) <<< F) + CA1 * m_fk1 + CA2 * m_fk2));
      y = sat_n(scale_down(CB0 * f + CB1 * m_fk1 + CB2 * m_fk2));
      m_fk2 = m_fk1;
      m_fk1 = f;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b0;
      sample_in = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      m_fk1 = 0;
      m_fk2 = 0;
   endtask

   // Present one sample, drop in_valid after the accept edge, and return the frame results.
   task automatic run_frame(input longint s, output longint got_fk, output longint got_yk,
                            output int busy, output logic yv);
      @(negedge clk);
      in_valid = 1'b1;
      sample_in = N'(s);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      busy = 0;
      while (!in_ready && busy < 20) begin
         busy++;
         @(negedge clk);
      end
      got_fk = fk;
      got_yk = yk;
      yv = y_valid;
   endtask

   typedef struct {
      bit     pre_reset;
      longint sample;
      longint exp_fk;
      longint exp_yk;
   } vec_t;

   vec_t   vecs[5];
   longint gf, gy, ef, ey, f_ref, y_ref;
   int     busy;
   logic   yv, yv_seen;
   logic signed [N-1:0] r;

   initial begin
      vecs[0] = '{1'b1, 0, 0, 0};
      vecs[1] = '{1'b0, 0, 0, 0};
      vecs[2] = '{1'b0, 0, 0, 0};
      vecs[3] = '{1'b1, 16384, 16384, 3};
      vecs[4] = '{1'b0, 0, 32112, IMP_Y1};

      // Reset state
      do_reset();
      #1;
      check("rst_fk", fk, 0);
      check("rst_fk1", fk1, 0);
      check("rst_fk2", fk2, 0);
      check("rst_uk", Uk, 0);
      check("rst_yk", yk, 0);
      check("rst_yvalid", y_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_sel", {controlS, controlC, controlZ}, 0);

      // Zero frames and impulse response
      for (int i = 0; i < 5; i++) begin
         if (vecs[i].pre_reset) do_reset();
         run_frame(vecs[i].sample, gf, gy, busy, yv);
         check($sformatf("vec%0d_fk", i), gf, vecs[i].exp_fk);
         check($sformatf("vec%0d_yk", i), gy, vecs[i].exp_yk);
         check($sformatf("vec%0d_busy", i), busy, 8);
         check($sformatf("vec%0d_yvalid", i), yv, 1);
      end

      // in_valid held high: accepts back to back, y_valid once per 9 cycles
      do_reset();
      @(negedge clk);
      in_valid = 1'b1;
      sample_in = '0;
      for (int j = 1; j <= 45; j++) begin
         @(negedge clk);
         check($sformatf("hold_yvalid_c%0d", j), y_valid, longint'(j % 9 == 0));
         check($sformatf("hold_ready_c%0d", j), in_ready, longint'(j % 9 == 0));
      end
      in_valid = 1'b0;
      busy = 0;
      while (!in_ready && busy < 20) begin
         busy++;
         @(negedge clk);
      end
      check("hold_drain", in_ready, 1);

      // Full-scale input: saturates without wrapping
      do_reset();
      for (int i = 0; i < 20; i++) begin
         run_frame(MAXV, gf, gy, busy, yv);
         model_step(MAXV, ef, ey);
         check($sformatf("sat%0d_fk", i), gf, ef);
         check($sformatf("sat%0d_yk", i), gy, ey);
      end
      check("sat_fk_clamped", gf, MAXV);

      // Reset during MB1 abandons the frame
      do_reset();
      run_frame(12345, f_ref, y_ref, busy, yv);
      model_step(12345, ef, ey);
      check("mid_ref_yk", y_ref, ey);
      do_reset();
      @(negedge clk);
      in_valid = 1'b1;
      sample_in = N'(-5000);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("mid_fk_before", fk, -5000);
      reset = 1'b0;
      #1;
      check("mid_fk", fk, 0);
      check("mid_fk1", fk1, 0);
      check("mid_fk2", fk2, 0);
      check("mid_uk", Uk, 0);
      check("mid_yk", yk, 0);
      check("mid_sel", {controlS, controlC, controlZ}, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      m_fk1 = 0;
      m_fk2 = 0;
      yv_seen = 1'b0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (y_valid) yv_seen = 1'b1;
      end
      check("mid_no_yvalid", yv_seen, 0);
      run_frame(12345, gf, gy, busy, yv);
      check("mid_after_fk", gf, f_ref);
      check("mid_after_yk", gy, y_ref);
      model_step(12345, ef, ey);

      // in_valid raised during MA2 waits for IDLE
      do_reset();
      @(negedge clk);
      in_valid = 1'b1;
      sample_in = N'(7000);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      in_valid = 1'b1;
      sample_in = N'(-3000);
      busy = 0;
      while (!in_ready && busy < 20) begin
         check("ma2_uk_hold", Uk, 7000);
         busy++;
         @(negedge clk);
      end
      check("ma2_busy", busy, 6);
      model_step(7000, ef, ey);
      check("ma2_first_yk", yk, ey);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("ma2_uk_new", Uk, -3000);
      busy = 0;
      while (!in_ready && busy < 20) begin
         busy++;
         @(negedge clk);
      end
      model_step(-3000, ef, ey);
      check("ma2_second_fk", fk, ef);
      check("ma2_second_yk", yk, ey);

      // Randomized frames with idle gaps
      do_reset();
      for (int i = 0; i < 25; i++) begin
         if (i < 12) r = N'($urandom_range(0, 4000)) - N'(2000);
         else        r = N'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_frame(longint'(r), gf, gy, busy, yv);
         model_step(longint'(r), ef, ey);
         check($sformatf("rnd%0d_fk", i), gf, ef);
         check($sformatf("rnd%0d_yk", i), gy, ey);
         check($sformatf("rnd%0d_yvalid", i), yv, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
